// File: rtl/dmem_responder.sv
// Latency-configurable data-memory target: serialized load/store requests over
// valid/ready, with byte/half/word lanes, load extension and fault reporting.
module dmem_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0100_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          LATENCY     = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        req_rw,
  input  logic [1:0]  req_size,
  input  logic        req_sign,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  // Handshake: a request moves on a rising edge with req_valid && req_ready,
  // a response moves on a rising edge with resp_valid && resp_ready; the two
  // readies are never high together, so accesses are strictly serialized.
  localparam int          IDXW = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d;
  logic        rw_q, rw_d, sign_q, sign_d;
  logic [1:0]  size_q, size_d;
  logic        req_ready_q, req_ready_d, resp_valid_q, resp_valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;

  logic [31:0] mem [DEPTH_WORDS];

  logic [31:0] cur_addr, cur_wdata;
  logic        cur_rw, cur_sign;
  logic [1:0]  cur_size, lane;
  logic [32:0] diff;
  logic        in_range, acc_err, do_access, mem_we;
  logic [IDXW-1:0] idx;
  logic [31:0] old_word, new_word, acc_rdata;
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  // With LATENCY=1 the access happens on the accept edge, straight from the bus.
  always_comb begin
    cur_addr  = (state_q == S_IDLE) ? req_addr  : addr_q;
    cur_wdata = (state_q == S_IDLE) ? req_wdata : wdata_q;
    cur_rw    = (state_q == S_IDLE) ? req_rw    : rw_q;
    cur_size  = (state_q == S_IDLE) ? req_size  : size_q;
    cur_sign  = (state_q == S_IDLE) ? req_sign  : sign_q;
    lane      = cur_addr[1:0];
    // 33-bit difference: the borrow flags addresses below the base, no wrap.
    diff      = {1'b0, cur_addr} - {1'b0, BASE_ADDR};
    in_range  = !diff[32] && (diff[31:0] < SPAN);
    idx       = diff[IDXW+1:2];
    acc_err   = !in_range || (cur_size == 2'b11) ||
                (cur_size == 2'b01 && cur_addr[0]) ||
                (cur_size == 2'b10 && cur_addr[1:0] != 2'b00);
    old_word  = mem[idx];
    sel_byte  = old_word[{lane, 3'b000} +: 8];
    sel_half  = cur_addr[1] ? old_word[31:16] : old_word[15:0];
    new_word  = old_word;
    acc_rdata = 32'h0;
    case (cur_size)
      2'b00: begin
        new_word[{lane, 3'b000} +: 8] = cur_wdata[7:0];
        acc_rdata = {{24{cur_sign & sel_byte[7]}}, sel_byte};
      end
      2'b01: begin
        if (cur_addr[1]) new_word[31:16] = cur_wdata[15:0];
        else             new_word[15:0]  = cur_wdata[15:0];
        acc_rdata = {{16{cur_sign & sel_half[15]}}, sel_half};
      end
      2'b10: begin
        new_word  = cur_wdata;
        acc_rdata = old_word;
      end
      default: acc_rdata = 32'h0;
    endcase
    if (acc_err || cur_rw) acc_rdata = 32'h0;
    do_access = ((state_q == S_IDLE) && req_valid && (LATENCY == 1)) ||
                ((state_q == S_WAIT) && (cnt_q == 4'd0));
    mem_we    = do_access && cur_rw && !acc_err && reset;
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rw_d         = rw_q;
    size_d       = size_q;
    sign_d       = sign_q;
    req_ready_d  = req_ready_q;
    resp_valid_d = resp_valid_q;
    rdata_d      = rdata_q;
    err_d        = err_q;
    case (state_q)
      S_IDLE: if (req_valid) begin
        addr_d      = req_addr;
        wdata_d     = req_wdata;
        rw_d        = req_rw;
        size_d      = req_size;
        sign_d      = req_sign;
        req_ready_d = 1'b0;
        cnt_d       = 4'(LATENCY - 1);
        state_d     = (LATENCY == 1) ? S_RESP : S_WAIT;
      end
      S_WAIT: if (cnt_q != 4'd0) cnt_d = cnt_q - 4'd1;
              else state_d = S_RESP;
      S_RESP: if (resp_ready) begin
        state_d      = S_IDLE;
        resp_valid_d = 1'b0;
        req_ready_d  = 1'b1;
        rdata_d      = 32'h0;
        err_d        = 1'b0;
      end
      default: begin
        state_d      = S_IDLE;
        req_ready_d  = 1'b1;
        resp_valid_d = 1'b0;
      end
    endcase
    if (do_access) begin
      resp_valid_d = 1'b1;
      rdata_d      = acc_rdata;
      err_d        = acc_err;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= 4'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      rw_q         <= 1'b0;
      size_q       <= 2'b00;
      sign_q       <= 1'b0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      rdata_q      <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rw_q         <= rw_d;
      size_q       <= size_d;
      sign_q       <= sign_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      rdata_q      <= rdata_d;
      err_q        <= err_d;
    end
  end

  // Storage is deliberately not reset; contents survive a reset pulse.
  always_ff @(posedge clock) begin
    if (mem_we) mem[idx] <= new_word;
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed vector table, reset/stall sequences and
// randomized traffic against a byte-array memory model.
module tb_dmem_responder;

  localparam logic [31:0] BASE  = 32'h0100_0000;
  localparam int          DEPTH = 1024;
  localparam int          LAT   = 2;

  logic        clock, reset;
  logic        req_valid, req_ready, req_rw, req_sign;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;
  logic [1:0]  dbg_state;

  dmem_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH), .LATENCY(LAT)) u_dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_rw(req_rw), .req_size(req_size), .req_sign(req_sign),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .dbg_state(dbg_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Invariants watched every cycle: readies exclusive, stalled response stable.
  logic        hold_chk = 1'b0;
  logic [31:0] hold_rdata;
  logic        hold_err;
  always @(posedge clock) begin
    hold_chk   = (reset === 1'b1) && resp_valid && !resp_ready;
    hold_rdata = resp_rdata;
    hold_err   = resp_err;
  end
  always @(negedge clock) begin
    if (reset === 1'b1) begin
      check("ready_valid_excl", {31'b0, resp_valid & req_ready}, 32'h0);
      if (hold_chk) begin
        check("stall_valid", {31'b0, resp_valid}, 32'h1);
        check("stall_rdata", resp_rdata, hold_rdata);
        check("stall_err", {31'b0, resp_err}, {31'b0, hold_err});
      end
    end
  end

  // Reference memory: a flat byte array addressed by offset from BASE.
  logic [7:0] mm [0:4*DEPTH-1];

  function automatic void model(input logic rw, input logic [1:0] size, input logic sign,
                                input logic [31:0] addr, input logic [31:0] wdata,
                                output logic [31:0] rd, output logic err);
    longint off = longint'(addr) - longint'(BASE);
    int     n   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    longint v   = 0;
    err = (size == 2'd3) || (longint'(addr) % n != 0) || (off < 0) || (off >= 4 * DEPTH);
    rd  = 32'h0;
    if (err) return;
    if (rw) begin
      for (int i = 0; i < n; i++) mm[int'(off) + i] = wdata[8*i +: 8];
    end else begin
      for (int i = 0; i < n; i++) v = v + (longint'(mm[int'(off) + i]) << (8 * i));
      if (sign && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
      rd = 32'(v);
    end
  endfunction

  task automatic do_txn(input logic rw, input logic [1:0] size, input logic sign,
                        input logic [31:0] addr, input logic [31:0] wdata, input int delay,
                        output logic [31:0] rdata, output logic err, output int lat);
    rdata = 32'h0;
    err   = 1'b0;
    lat   = 0;
    @(negedge clock);
    check("idle_ready", {31'b0, req_ready}, 32'h1);
    req_valid = 1'b1; req_rw = rw; req_size = size; req_sign = sign;
    req_addr  = addr; req_wdata = wdata;
    @(posedge clock);
    #1;
    // Keep junk on the bus while busy; it must be ignored.
    req_addr = $urandom; req_wdata = $urandom; req_rw = 1'($urandom);
    req_size = 2'($urandom); req_sign = 1'($urandom);
    for (int c = 0; c < 40; c++) begin
      @(posedge clock);
      lat++;
      @(negedge clock);
      if (resp_valid) break;
    end
    if (!resp_valid) begin
      check("resp_timeout", 32'h0, 32'h1);
      req_valid = 1'b0;
      lat = -1;
      return;
    end
    for (int k = 0; k < delay; k++) begin
      check("hold_valid", {31'b0, resp_valid}, 32'h1);
      check("hold_ready", {31'b0, req_ready}, 32'h0);
      @(negedge clock);
    end
    rdata = resp_rdata;
    err   = resp_err;
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    check("post_consume_valid", {31'b0, resp_valid}, 32'h0);
    check("post_consume_ready", {31'b0, req_ready}, 32'h1);
  endtask

  typedef struct {
    logic        rw;
    logic [1:0]  size;
    logic        sign;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd, exp_rd;
    logic        er, exp_er;
    int          lat;

    reset = 1'b0; req_valid = 1'b0; req_rw = 1'b0; req_size = 2'b00; req_sign = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_req_ready", {31'b0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_err", {31'b0, resp_err}, 32'h0);
    reset = 1'b1;

    //                rw    size  sg    addr           wdata          rdata          err
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0100_0010, 32'hDEAD_BEEF, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'h0,         32'hDEAD_BEEF, 1'b0});
    vecs.push_back('{1'b1, 2'd0, 1'b0, 32'h0100_0011, 32'hAAAA_557F, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0100_0010, 32'h0,         32'h0000_7FEF, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0100_0013, 32'h0,         32'hFFFF_FFDE, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b0, 32'h0100_0013, 32'h0,         32'h0000_00DE, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0100_0011, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0100_0012, 32'h1111_1111, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'h0,         32'hDEAD_7FEF, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h00FF_FFFC, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_1000, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 2'd3, 1'b0, 32'h0100_0010, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b1, 2'd3, 1'b0, 32'h0100_0010, 32'h2222_2222, 32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_0012, 32'h0,         32'h0000_0000, 1'b1});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'h0,         32'hDEAD_7FEF, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0100_0FFC, 32'hA5A5_5A5A, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_0FFC, 32'h0,         32'hA5A5_5A5A, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 1'b1, 32'h0100_0012, 32'h0,         32'hFFFF_DEAD, 1'b0});
    vecs.push_back('{1'b0, 2'd1, 1'b0, 32'h0100_0012, 32'h0,         32'h0000_DEAD, 1'b0});
    vecs.push_back('{1'b1, 2'd1, 1'b0, 32'h0100_0012, 32'hFFFF_8001, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'h0,         32'h8001_7FEF, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0100_0012, 32'h0,         32'h0000_0001, 1'b0});
    vecs.push_back('{1'b0, 2'd0, 1'b1, 32'h0100_0013, 32'h0,         32'hFFFF_FF80, 1'b0});
    vecs.push_back('{1'b1, 2'd2, 1'b0, 32'h0100_0020, 32'h1111_2222, 32'h0000_0000, 1'b0});
    vecs.push_back('{1'b0, 2'd2, 1'b0, 32'h0100_0020, 32'h0,         32'h1111_2222, 1'b0});

    foreach (vecs[i]) begin
      do_txn(vecs[i].rw, vecs[i].size, vecs[i].sign, vecs[i].addr, vecs[i].wdata, 0, rd, er, lat);
      check($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(LAT));
    end

    // Stall in RESP for 5 cycles, then release.
    do_txn(1'b0, 2'd2, 1'b0, 32'h0100_0010, 32'h0, 5, rd, er, lat);
    check("stall_load_rdata", rd, 32'h8001_7FEF);
    check("stall_load_err", {31'b0, er}, 32'h0);

    // Reset one cycle after accepting a store: store must be abandoned.
    @(negedge clock);
    req_valid = 1'b1; req_rw = 1'b1; req_size = 2'd2; req_sign = 1'b0;
    req_addr = 32'h0100_0020; req_wdata = 32'h1234_5678;
    @(posedge clock);
    #1 req_valid = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("midrst_req_ready", {31'b0, req_ready}, 32'h1);
    check("midrst_resp_valid", {31'b0, resp_valid}, 32'h0);
    check("midrst_rdata", resp_rdata, 32'h0);
    check("midrst_err", {31'b0, resp_err}, 32'h0);
    repeat (2) @(negedge clock);
    reset = 1'b1;
    do_txn(1'b0, 2'd2, 1'b0, 32'h0100_0020, 32'h0, 0, rd, er, lat);
    check("midrst_load_rdata", rd, 32'h1111_2222);
    check("midrst_load_err", {31'b0, er}, 32'h0);

    // Random traffic: seed a 32-word window, then mixed accesses.
    for (int w = 0; w < 32; w++) begin
      logic [31:0] a, d;
      a = BASE + 32'h100 + 32'(4 * w);
      d = $urandom;
      model(1'b1, 2'd2, 1'b0, a, d, exp_rd, exp_er);
      do_txn(1'b1, 2'd2, 1'b0, a, d, 0, rd, er, lat);
      check("seed_err", {31'b0, er}, {31'b0, exp_er});
    end
    for (int t = 0; t < 200; t++) begin
      logic [31:0] a, d;
      logic        rw, sg;
      logic [1:0]  sz;
      int          pick, dly;
      pick = $urandom_range(0, 11);
      case (pick)
        8:       a = BASE - 32'd4;
        9:       a = BASE - 32'd1;
        10:      a = BASE + 32'(4 * DEPTH);
        11:      a = 32'hFFFF_FFFC;
        default: a = BASE + 32'h100 + 32'($urandom_range(0, 127));
      endcase
      rw  = 1'($urandom);
      sg  = 1'($urandom);
      sz  = 2'($urandom_range(0, 3));
      d   = $urandom;
      dly = $urandom_range(0, 2);
      model(rw, sz, sg, a, d, exp_rd, exp_er);
      do_txn(rw, sz, sg, a, d, dly, rd, er, lat);
      check($sformatf("rnd%0d_rdata", t), rd, exp_rd);
      check($sformatf("rnd%0d_err", t), {31'b0, er}, {31'b0, exp_er});
      check($sformatf("rnd%0d_latency", t), 32'(lat), 32'(LAT));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
